// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter between video scan-out and CPU.
package sram_arb_pkg;

    localparam int DEFAULT_AW = 14;
    localparam int DW         = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/sram_arb_return.sv
// Read-return pipeline: carries the owner of each issued access for one cycle,
// then steers the SRAM pad data into that owner's rdata with a one-cycle rvalid.
module sram_arb_return
    import sram_arb_pkg::*;
(
    input  logic          clk_core,
    input  logic          reset,
    input  owner_e        issue_owner,
    input  logic [DW-1:0] sram_to_host,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata
);

    owner_e owner_q;

    // owner_q lines up with the access currently on the pads; data is captured as that cycle ends
    always_ff @(posedge clk_core) begin
        if (reset) begin
            owner_q    <= OWN_NONE;
            vid_rvalid <= 1'b0;
            vid_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            owner_q    <= issue_owner;
            vid_rvalid <= (owner_q == OWN_VID);
            cpu_rvalid <= (owner_q == OWN_CPU);
            if (owner_q == OWN_VID) begin
                vid_rdata <= sram_to_host;
            end
            if (owner_q == OWN_CPU) begin
                cpu_rdata <= sram_to_host;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the shared asynchronous SRAM: video has priority, the CPU is
// forced through after MAX_STALL lost cycles, and a write-to-read turnaround is optional.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW         = DEFAULT_AW,
    parameter int MAX_STALL  = 3,
    parameter int TURNAROUND = 1
) (
    input  logic          clk_core,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] sram_a,
    output logic          sram_wr,
    output logic [DW-1:0] host_to_sram,
    input  logic [DW-1:0] sram_to_host
);

    localparam int SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

    logic [SW-1:0] stall_cnt;
    logic          turn_active;
    logic          vid_blocked;
    logic          cpu_blocked;
    logic          force_cpu;
    owner_e        issue_owner;

    assign turn_active = (TURNAROUND != 0) && sram_wr;
    assign vid_blocked = turn_active;
    assign cpu_blocked = turn_active && !cpu_we;
    assign force_cpu   = cpu_req && (stall_cnt == STALL_MAX);

    always_comb begin
        vid_gnt     = 1'b0;
        cpu_gnt     = 1'b0;
        issue_owner = OWN_NONE;
        if (!reset) begin
            if (force_cpu && !cpu_blocked) begin
                cpu_gnt = 1'b1;
            end else if (vid_req && !vid_blocked) begin
                vid_gnt = 1'b1;
            end else if (cpu_req && !cpu_blocked) begin
                cpu_gnt = 1'b1;
            end
        end
        if (vid_gnt) begin
            issue_owner = OWN_VID;
        end else if (cpu_gnt && !cpu_we) begin
            issue_owner = OWN_CPU;
        end
    end

    // Turnaround-blocked cycles count as lost cycles for the CPU as well
    always_ff @(posedge clk_core) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            sram_a       <= '0;
            sram_wr      <= 1'b0;
            host_to_sram <= '0;
        end else if (vid_gnt) begin
            sram_a       <= vid_addr;
            sram_wr      <= 1'b0;
            host_to_sram <= cpu_wdata;
        end else if (cpu_gnt) begin
            sram_a       <= cpu_addr;
            sram_wr      <= cpu_we;
            host_to_sram <= cpu_wdata;
        end else begin
            sram_wr      <= 1'b0;
        end
    end

    sram_arb_return u_return (
        .clk_core     (clk_core),
        .reset        (reset),
        .issue_owner  (issue_owner),
        .sram_to_host (sram_to_host),
        .vid_rvalid   (vid_rvalid),
        .vid_rdata    (vid_rdata),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata)
    );

endmodule
